// File: rtl/pipe_fifo_buffer.sv
// Registered-output circular FIFO with one-cycle read latency, flush, and
// registered full/empty/count. Sticky overflow/underflow flags exist only when
// the PIPE_FIFO_ERR_EN macro is defined; otherwise they are tied to 0.
module pipe_fifo_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     ref_clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     WE,
  input  logic [WIDTH-1:0]         DataI,
  input  logic                     RE,
  output logic [WIDTH-1:0]         DataO,
  output logic                     valid_o,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err,
  output logic                     unf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic          wrAccept;
  logic          rdAccept;
  logic [CW-1:0] countNext;

  // A full buffer still takes a write when the same cycle pops the head,
  // since that read frees the slot the write lands in.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    wrAccept  = WE && (!full || RE);
    rdAccept  = RE && !empty;
    countNext = count;
    if (wrAccept && !rdAccept) begin
      countNext = count + CW'(1);
    end else if (rdAccept && !wrAccept) begin
      countNext = count - CW'(1);
    end
  end

  always_ff @(posedge ref_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      valid_o <= 1'b0;
      DataO   <= '0;
    end else if (flush) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      if (wrAccept) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (rdAccept) begin
        rdPtr <= rdPtr + AW'(1);
        DataO <= mem[rdPtr];
      end
      valid_o <= rdAccept;
      count   <= countNext;
      full    <= (countNext == CW'(DEPTH));
      empty   <= (countNext == '0);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge ref_clk) begin
    if (!reset && !flush && wrAccept) begin
      mem[wrPtr] <= DataI;
    end
  end

`ifdef PIPE_FIFO_ERR_EN
  // Flags are sticky until reset; a flush cycle ignores requests, so it
  // can neither set nor clear them.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (!flush) begin
      if (WE && !wrAccept) begin
        ovf_err <= 1'b1;
      end
      if (RE && !rdAccept) begin
        unf_err <= 1'b1;
      end
    end
  end
`else
  assign ovf_err = 1'b0;
  assign unf_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_fifo_buffer.sv
// Bench for pipe_fifo_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_fifo_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
`ifdef PIPE_FIFO_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic             ref_clk = 1'b0;
  logic             reset   = 1'b0;
  logic             flush   = 1'b0;
  logic             WE      = 1'b0;
  logic             RE      = 1'b0;
  logic [WIDTH-1:0] DataI   = '0;
  logic [WIDTH-1:0] DataO;
  logic             valid_o;
  logic             full;
  logic             empty;
  logic [$clog2(DEPTH):0] count;
  logic             ovf_err;
  logic             unf_err;

  int checkCount = 0;
  int passCount  = 0;

  pipe_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ref_clk(ref_clk), .reset(reset), .flush(flush), .WE(WE), .DataI(DataI),
    .RE(RE), .DataO(DataO), .valid_o(valid_o), .full(full), .empty(empty),
    .count(count), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of words plus the last popped word.
  logic [WIDTH-1:0] mQ[$];
  logic [WIDTH-1:0] mDataO;
  bit mValid, mOvf, mUnf, modelLive;

  always @(posedge ref_clk) begin
    bit doRd, doWr;
    if (reset) begin
      mQ.delete();
      mDataO = '0; mValid = 0; mOvf = 0; mUnf = 0;
      modelLive = 1;
    end else if (flush) begin
      mQ.delete();
      mValid = 0;
    end else begin
      doRd = RE && (mQ.size() > 0);
      doWr = WE && ((mQ.size() < DEPTH) || RE);
      mValid = doRd;
      if (doRd) mDataO = mQ.pop_front();
      if (doWr) mQ.push_back(DataI);
      if (ERR_ON && WE && !doWr) mOvf = 1;
      if (ERR_ON && RE && !doRd) mUnf = 1;
    end
  end

  always @(posedge ref_clk) begin
    #1;
    if (modelLive) begin
      check("m_count", 64'(count), 64'(mQ.size()));
      check("m_full",  64'(full),  64'(mQ.size() == DEPTH));
      check("m_empty", 64'(empty), 64'(mQ.size() == 0));
      check("m_valid", 64'(valid_o), 64'(mValid));
      check("m_dataO", 64'(DataO), 64'(mDataO));
      check("m_ovf",   64'(ovf_err), 64'(mOvf));
      check("m_unf",   64'(unf_err), 64'(mUnf));
    end
  end

  task automatic step(input logic r, input logic f, input logic we, input logic re,
                      input logic [WIDTH-1:0] d);
    @(negedge ref_clk);
    reset = r; flush = f; WE = we; RE = re; DataI = d;
    @(posedge ref_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] held;
    logic sOvf, sUnf;
    int weW, reW;

    // Reset held for two cycles
    step(1, 0, 0, 0, '0);
    step(1, 0, 1, 1, 32'hFFFF);
    check("rst_dataO", 64'(DataO), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_empty", 64'(empty), 64'h1);
    check("rst_full",  64'(full),  64'h0);
    check("rst_valid", 64'(valid_o), 64'h0);
    check("rst_errs",  64'({ovf_err, unf_err}), 64'h0);

    // Fill
    step(0, 0, 1, 0, 32'h7FF);
    step(0, 0, 1, 0, 32'h1);
    step(0, 0, 1, 0, 32'h2);
    step(0, 0, 1, 0, 32'h3);
    check("fill_full",  64'(full),  64'h1);
    check("fill_count", 64'(count), 64'h4);

    // Full: WE alone rejected, then WE+RE keeps count at DEPTH
    step(0, 0, 1, 0, 32'hDEAD);
    check("ovf_count", 64'(count), 64'h4);
    check("ovf_flag",  64'(ovf_err), 64'(ERR_ON));
    check("ovf_valid", 64'(valid_o), 64'h0);
    step(0, 0, 1, 1, 32'h4);
    check("fullwr_count", 64'(count), 64'h4);
    check("fullwr_dataO", 64'(DataO), 64'h7FF);
    check("fullwr_valid", 64'(valid_o), 64'h1);

    // Drain: order preserved, 0xDEAD never stored
    step(0, 0, 0, 1, '0);
    check("drain0", 64'(DataO), 64'h1);
    check("drain0_v", 64'(valid_o), 64'h1);
    step(0, 0, 0, 1, '0);
    check("drain1", 64'(DataO), 64'h2);
    step(0, 0, 0, 1, '0);
    check("drain2", 64'(DataO), 64'h3);
    step(0, 0, 0, 1, '0);
    check("drain3", 64'(DataO), 64'h4);
    check("drain_empty", 64'(empty), 64'h1);

    // Empty: RE alone ignored; WE+RE accepts only the write
    step(0, 0, 0, 1, '0);
    check("unf_valid", 64'(valid_o), 64'h0);
    check("unf_dataO", 64'(DataO), 64'h4);
    check("unf_flag",  64'(unf_err), 64'(ERR_ON));
    step(0, 0, 1, 1, 32'h55);
    check("emptywr_count", 64'(count), 64'h1);
    check("emptywr_valid", 64'(valid_o), 64'h0);
    step(0, 0, 0, 1, '0);
    check("emptywr_data", 64'(DataO), 64'h55);

    // Wrap-around: ten write/read pairs
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, WIDTH'(i));
      step(0, 0, 0, 1, '0);
      check("wrap_data",  64'(DataO), 64'(i));
      check("wrap_valid", 64'(valid_o), 64'h1);
    end

    // Flush at count=3, with requests asserted that must be ignored
    step(0, 0, 1, 0, 32'hA);
    step(0, 0, 1, 0, 32'hB);
    step(0, 0, 1, 0, 32'hC);
    check("preflush_count", 64'(count), 64'h3);
    sOvf = ovf_err; sUnf = unf_err;
    step(0, 1, 1, 1, 32'hE);
    check("flush_count", 64'(count), 64'h0);
    check("flush_empty", 64'(empty), 64'h1);
    check("flush_dataO", 64'(DataO), 64'h9);
    check("flush_valid", 64'(valid_o), 64'h0);
    check("flush_errs",  64'({ovf_err, unf_err}), 64'({sOvf, sUnf}));

    // Mid-stream reset discards entries in the same edge
    step(0, 0, 1, 0, 32'h11);
    step(0, 0, 1, 0, 32'h22);
    step(1, 0, 1, 1, 32'h33);
    check("midrst_count", 64'(count), 64'h0);
    check("midrst_dataO", 64'(DataO), 64'h0);
    check("midrst_errs",  64'({ovf_err, unf_err}), 64'h0);

    // Randomized traffic with shifting read/write bias
    for (int p = 0; p < 8; p++) begin
      weW = (p % 4) * 30 + 10;
      reW = ((p + 2) % 4) * 30 + 10;
      for (int c = 0; c < 250; c++) begin
        step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 99) < weW, $urandom_range(0, 99) < reW, $urandom);
      end
    end

    step(0, 0, 0, 0, '0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
